// File: rtl/fetch_bht_predictor_pkg.sv
// Shared decode constants, 2-bit counter encodings and the counter update rule
// for the fetch-stage branch history table predictor.
package fetch_bht_predictor_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating 2-bit counter step: taken climbs toward ST, not-taken falls toward SNT.
  function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'b01;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_bht_predictor_bht_table.sv
// Array of 2-bit saturating counters: asynchronous lookup port, synchronous
// training port, and a single-cycle synchronous reset of every entry to CNT_INIT.
module bht_table
  import fetch_bht_predictor_pkg::*;
#(
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  localparam int        IDX       = $clog2(BHT_DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [IDX-1:0] rd_idx_i,
  output logic [1:0]     rd_cnt_o,
  input  logic           wr_en_i,
  input  logic [IDX-1:0] wr_idx_i,
  input  logic           wr_taken_i
);

  logic [1:0] r_cnt [BHT_DEPTH];

  assign rd_cnt_o = r_cnt[rd_idx_i];

  // Reset wins over a coincident training write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_cnt[i] <= CNT_INIT;
      end
    end else if (wr_en_i) begin
      r_cnt[wr_idx_i] <= sat2_next(r_cnt[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/fetch_bht_predictor.sv
// Fetch-stage next-PC predictor: RV32I branch/jal mini-decode, target add, BHT
// direction lookup, execute-side training and perf counters. Optional PRED_GSHARE_EN.
module fetch_bht_predictor
  import fetch_bht_predictor_pkg::*;
#(
  parameter int         PC_WIDTH   = 32,
  parameter int         XLEN       = 32,
  parameter int         BHT_DEPTH  = 64,
  parameter logic [1:0] CNT_INIT   = 2'b01,
  parameter int         PERF_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PC_WIDTH-1:0]   F_PC_i,
  input  logic [31:0]           F_instr_i,
  output logic                  mini_jmp_sel_o,
  output logic [XLEN-1:0]       mini_jmp_o,
  output logic                  F_train_vaild_o,
  output logic                  F_train_predict_o,
  input  logic                  E_train_vaild_i,
  input  logic [PC_WIDTH-1:0]   E_train_pc_i,
  input  logic                  E_train_taken_i,
  input  logic                  E_train_mispredict_i,
  output logic [PERF_WIDTH-1:0] perf_branch_o,
  output logic [PERF_WIDTH-1:0] perf_mispred_o
);

  localparam int IDX = $clog2(BHT_DEPTH);

  logic            w_op_branch;
  logic            w_op_jal;
  logic [12:0]     w_bimm;
  logic [20:0]     w_jimm;
  logic [XLEN-1:0] w_imm;
  logic [IDX-1:0]  w_rd_idx;
  logic [IDX-1:0]  w_wr_idx;
  logic [1:0]      w_rd_cnt;
  logic            w_unused_pc_bits;

  logic [PERF_WIDTH-1:0] r_perf_branch;
  logic [PERF_WIDTH-1:0] r_perf_mispred;

  assign w_op_branch = (F_instr_i[6:0] == OPC_BRANCH);
  assign w_op_jal    = (F_instr_i[6:0] == OPC_JAL);

  assign w_bimm = {F_instr_i[31], F_instr_i[7], F_instr_i[30:25], F_instr_i[11:8], 1'b0};
  assign w_jimm = {F_instr_i[31], F_instr_i[19:12], F_instr_i[20], F_instr_i[30:21], 1'b0};

  always_comb begin
    w_imm = '0;
    if (w_op_branch) begin
      w_imm = {{(XLEN-13){w_bimm[12]}}, w_bimm};
    end else if (w_op_jal) begin
      w_imm = {{(XLEN-21){w_jimm[20]}}, w_jimm};
    end
  end

  assign mini_jmp_o        = XLEN'(F_PC_i) + w_imm;
  assign F_train_vaild_o   = w_op_branch;
  assign F_train_predict_o = w_op_branch & w_rd_cnt[1];
  assign mini_jmp_sel_o    = w_op_jal | F_train_predict_o;

`ifdef PRED_GSHARE_EN
  logic [IDX-1:0] r_ghr;
  logic [IDX-1:0] r_ghr_fetch;

  // The snapshot ties a resolving branch back to the history it was looked up with.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ghr       <= '0;
      r_ghr_fetch <= '0;
    end else begin
      if (E_train_vaild_i) r_ghr <= {r_ghr[IDX-2:0], E_train_taken_i};
      if (w_op_branch)     r_ghr_fetch <= r_ghr;
    end
  end

  assign w_rd_idx = F_PC_i[IDX+1:2] ^ r_ghr;
  assign w_wr_idx = E_train_pc_i[IDX+1:2] ^ r_ghr_fetch;
`else
  assign w_rd_idx = F_PC_i[IDX+1:2];
  assign w_wr_idx = E_train_pc_i[IDX+1:2];
`endif

  assign w_unused_pc_bits = ^{F_PC_i[PC_WIDTH-1:IDX+2], F_PC_i[1:0],
                              E_train_pc_i[PC_WIDTH-1:IDX+2], E_train_pc_i[1:0]};

  bht_table #(
    .BHT_DEPTH (BHT_DEPTH),
    .CNT_INIT  (CNT_INIT)
  ) u_bht_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (w_rd_idx),
    .rd_cnt_o   (w_rd_cnt),
    .wr_en_i    (E_train_vaild_i),
    .wr_idx_i   (w_wr_idx),
    .wr_taken_i (E_train_taken_i)
  );

  // Perf counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_branch  <= '0;
      r_perf_mispred <= '0;
    end else if (E_train_vaild_i) begin
      if (r_perf_branch != '1) r_perf_branch <= r_perf_branch + 1'b1;
      if (E_train_mispredict_i && (r_perf_mispred != '1)) r_perf_mispred <= r_perf_mispred + 1'b1;
    end
  end

  assign perf_branch_o  = r_perf_branch;
  assign perf_mispred_o = r_perf_mispred;

endmodule

// File: tb/tb_fetch_bht_predictor.sv
// Scoreboard bench for fetch_bht_predictor: default instance plus a PERF_WIDTH=4
// instance sharing the same stimulus for perf-counter saturation.
module tb_fetch_bht_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] F_PC_i;
  logic [31:0] F_instr_i;
  logic        E_train_vaild_i;
  logic [31:0] E_train_pc_i;
  logic        E_train_taken_i;
  logic        E_train_mispredict_i;

  logic        mini_jmp_sel_o;
  logic [31:0] mini_jmp_o;
  logic        F_train_vaild_o;
  logic        F_train_predict_o;
  logic [31:0] perf_branch_o;
  logic [31:0] perf_mispred_o;

  logic        sel4;
  logic [31:0] jmp4;
  logic        vld4;
  logic        pred4;
  logic [3:0]  perf4Branch;
  logic [3:0]  perf4Mispred;

  typedef struct {
    string       name;
    logic        sel;
    logic [31:0] jmp;
    logic        vld;
    logic        pred;
  } fetchExp_t;

  typedef struct {
    string       name;
    logic [31:0] branch;
    logic [31:0] mispred;
    logic [3:0]  branch4;
    logic [3:0]  mispred4;
  } perfExp_t;

  fetchExp_t fetchQ[$];
  perfExp_t  perfQ[$];
  fetchExp_t fe;
  perfExp_t  pe;
  int        nChecks = 0;
  int        nFails  = 0;

  always #5 clk_i = ~clk_i;

  fetch_bht_predictor dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .F_PC_i               (F_PC_i),
    .F_instr_i            (F_instr_i),
    .mini_jmp_sel_o       (mini_jmp_sel_o),
    .mini_jmp_o           (mini_jmp_o),
    .F_train_vaild_o      (F_train_vaild_o),
    .F_train_predict_o    (F_train_predict_o),
    .E_train_vaild_i      (E_train_vaild_i),
    .E_train_pc_i         (E_train_pc_i),
    .E_train_taken_i      (E_train_taken_i),
    .E_train_mispredict_i (E_train_mispredict_i),
    .perf_branch_o        (perf_branch_o),
    .perf_mispred_o       (perf_mispred_o)
  );

  fetch_bht_predictor #(.PERF_WIDTH(4)) dut4 (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .F_PC_i               (F_PC_i),
    .F_instr_i            (F_instr_i),
    .mini_jmp_sel_o       (sel4),
    .mini_jmp_o           (jmp4),
    .F_train_vaild_o      (vld4),
    .F_train_predict_o    (pred4),
    .E_train_vaild_i      (E_train_vaild_i),
    .E_train_pc_i         (E_train_pc_i),
    .E_train_taken_i      (E_train_taken_i),
    .E_train_mispredict_i (E_train_mispredict_i),
    .perf_branch_o        (perf4Branch),
    .perf_mispred_o       (perf4Mispred)
  );

  // beq x0,x0 with a 13-bit branch offset
  function automatic logic [31:0] encB(input int imm);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], 5'd0, 5'd0, 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  // jal x1 with a 21-bit jump offset
  function automatic logic [31:0] encJ(input int imm);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr, input string name,
                               input logic sel, input logic [31:0] jmp, input logic vld,
                               input logic pred);
    F_PC_i    = pc;
    F_instr_i = instr;
    fetchQ.push_back('{name: name, sel: sel, jmp: jmp, vld: vld, pred: pred});
  endtask

  task automatic expectPerf(input string name, input logic [31:0] br, input logic [31:0] mp,
                            input logic [3:0] br4, input logic [3:0] mp4);
    perfQ.push_back('{name: name, branch: br, mispred: mp, branch4: br4, mispred4: mp4});
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic trainOp(input logic [31:0] pc, input logic taken, input logic mis);
    @(negedge clk_i);
    E_train_vaild_i      = 1'b1;
    E_train_pc_i         = pc;
    E_train_taken_i      = taken;
    E_train_mispredict_i = mis;
    @(negedge clk_i);
    E_train_vaild_i      = 1'b0;
    E_train_mispredict_i = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    expectPerf("reset_perf", 32'd0, 32'd0, 4'd0, 4'd0);
    #1;
    pe = perfQ.pop_front();
    nChecks++;
    if ({perf_branch_o, perf_mispred_o, perf4Branch, perf4Mispred} !== {pe.branch, pe.mispred, pe.branch4, pe.mispred4}) begin
      nFails++;
      $display("[TB] FAIL %s: got br=%0d mp=%0d br4=%0d mp4=%0d expected br=%0d mp=%0d br4=%0d mp4=%0d",
               pe.name, perf_branch_o, perf_mispred_o, perf4Branch, perf4Mispred,
               pe.branch, pe.mispred, pe.branch4, pe.mispred4);
    end
  endtask

  task automatic test_decode();
    logic [31:0] pcs   [5] = '{32'h100, 32'h200, 32'h300, 32'h0, 32'h1000};
    logic [31:0] instrs[5];
    logic [31:0] jmps  [5] = '{32'h110, 32'h1F8, 32'h300, 32'hFFFF_FFFC, 32'h1800};
    logic        sels  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        vlds  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    instrs = '{encB(16), encJ(-8), 32'h0010_0093, encB(-4), encJ(2048)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      applyStimulus(pcs[i], instrs[i], $sformatf("decode_%0d", i), sels[i], jmps[i], vlds[i], 1'b0);
      #1;
      fe = fetchQ.pop_front();
      nChecks++;
      if ({mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o} !== {fe.sel, fe.jmp, fe.vld, fe.pred}) begin
        nFails++;
        $display("[TB] FAIL %s: sel/jmp/vld/pred got %b/%h/%b/%b expected %b/%h/%b/%b", fe.name,
                 mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o, fe.sel, fe.jmp, fe.vld, fe.pred);
      end
    end
  endtask

  task automatic test_train();
    // Each step: number of trainings, direction, then the expected prediction at 0x100.
    int   counts[5] = '{1, 1, 1, 4, 1};
    logic dirs  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic preds [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    doReset();
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < counts[s]; k++) trainOp(32'h100, dirs[s], 1'b0);
      applyStimulus(32'h100, encB(16), $sformatf("train_step_%0d", s), preds[s], 32'h110, 1'b1, preds[s]);
      #1;
      fe = fetchQ.pop_front();
      nChecks++;
      if ({mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o} !== {fe.sel, fe.jmp, fe.vld, fe.pred}) begin
        nFails++;
        $display("[TB] FAIL %s: sel/jmp/vld/pred got %b/%h/%b/%b expected %b/%h/%b/%b", fe.name,
                 mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o, fe.sel, fe.jmp, fe.vld, fe.pred);
      end
    end
  endtask

  task automatic test_alias();
    logic [31:0] pcs  [2] = '{32'h200, 32'h104};
    logic [31:0] jmps [2] = '{32'h210, 32'h114};
    logic        preds[2] = '{1'b1, 1'b0};
    doReset();
    trainOp(32'h100, 1'b1, 1'b0);
    trainOp(32'h100, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      applyStimulus(pcs[i], encB(16), $sformatf("alias_%0d", i), preds[i], jmps[i], 1'b1, preds[i]);
      #1;
      fe = fetchQ.pop_front();
      nChecks++;
      if ({mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o} !== {fe.sel, fe.jmp, fe.vld, fe.pred}) begin
        nFails++;
        $display("[TB] FAIL %s: sel/jmp/vld/pred got %b/%h/%b/%b expected %b/%h/%b/%b", fe.name,
                 mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o, fe.sel, fe.jmp, fe.vld, fe.pred);
      end
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    @(negedge clk_i);
    E_train_vaild_i = 1'b1;
    E_train_pc_i    = 32'h100;
    E_train_taken_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(32'h100, encB(16), $sformatf("same_cycle_%0d", i), i[0], 32'h110, 1'b1, i[0]);
      #1;
      fe = fetchQ.pop_front();
      nChecks++;
      if ({mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o} !== {fe.sel, fe.jmp, fe.vld, fe.pred}) begin
        nFails++;
        $display("[TB] FAIL %s: sel/jmp/vld/pred got %b/%h/%b/%b expected %b/%h/%b/%b", fe.name,
                 mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o, fe.sel, fe.jmp, fe.vld, fe.pred);
      end
      @(negedge clk_i);
      E_train_vaild_i = 1'b0;
    end
  endtask

  task automatic test_reset_priority();
    doReset();
    trainOp(32'h100, 1'b1, 1'b1);
    @(negedge clk_i);
    rst_i                = 1'b1;
    E_train_vaild_i      = 1'b1;
    E_train_pc_i         = 32'h100;
    E_train_taken_i      = 1'b1;
    E_train_mispredict_i = 1'b1;
    @(negedge clk_i);
    rst_i                = 1'b0;
    E_train_vaild_i      = 1'b0;
    E_train_mispredict_i = 1'b0;
    applyStimulus(32'h100, encB(16), "rst_prio_lookup", 1'b0, 32'h110, 1'b1, 1'b0);
    expectPerf("rst_prio_perf", 32'd0, 32'd0, 4'd0, 4'd0);
    #1;
    fe = fetchQ.pop_front();
    nChecks++;
    if ({mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o} !== {fe.sel, fe.jmp, fe.vld, fe.pred}) begin
      nFails++;
      $display("[TB] FAIL %s: sel/jmp/vld/pred got %b/%h/%b/%b expected %b/%h/%b/%b", fe.name,
               mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o, fe.sel, fe.jmp, fe.vld, fe.pred);
    end
    pe = perfQ.pop_front();
    nChecks++;
    if ({perf_branch_o, perf_mispred_o, perf4Branch, perf4Mispred} !== {pe.branch, pe.mispred, pe.branch4, pe.mispred4}) begin
      nFails++;
      $display("[TB] FAIL %s: got br=%0d mp=%0d br4=%0d mp4=%0d expected br=%0d mp=%0d br4=%0d mp4=%0d",
               pe.name, perf_branch_o, perf_mispred_o, perf4Branch, perf4Mispred,
               pe.branch, pe.mispred, pe.branch4, pe.mispred4);
    end
    // One taken from WNT must flip the prediction; from SNT it would not.
    trainOp(32'h100, 1'b1, 1'b0);
    applyStimulus(32'h100, encB(16), "rst_prio_init_wnt", 1'b1, 32'h110, 1'b1, 1'b1);
    #1;
    fe = fetchQ.pop_front();
    nChecks++;
    if ({mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o} !== {fe.sel, fe.jmp, fe.vld, fe.pred}) begin
      nFails++;
      $display("[TB] FAIL %s: sel/jmp/vld/pred got %b/%h/%b/%b expected %b/%h/%b/%b", fe.name,
               mini_jmp_sel_o, mini_jmp_o, F_train_vaild_o, F_train_predict_o, fe.sel, fe.jmp, fe.vld, fe.pred);
    end
  endtask

  task automatic test_perf();
    logic [31:0] pcs [5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    logic        tks [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        mis [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    doReset();
    for (int i = 0; i < 5; i++) trainOp(pcs[i], tks[i], mis[i]);
    @(negedge clk_i);
    E_train_mispredict_i = 1'b1;
    @(negedge clk_i);
    E_train_mispredict_i = 1'b0;
    expectPerf("perf_counts", 32'd5, 32'd2, 4'd5, 4'd2);
    #1;
    pe = perfQ.pop_front();
    nChecks++;
    if ({perf_branch_o, perf_mispred_o, perf4Branch, perf4Mispred} !== {pe.branch, pe.mispred, pe.branch4, pe.mispred4}) begin
      nFails++;
      $display("[TB] FAIL %s: got br=%0d mp=%0d br4=%0d mp4=%0d expected br=%0d mp=%0d br4=%0d mp4=%0d",
               pe.name, perf_branch_o, perf_mispred_o, perf4Branch, perf4Mispred,
               pe.branch, pe.mispred, pe.branch4, pe.mispred4);
    end
  endtask

  task automatic test_perf_saturate();
    doReset();
    for (int i = 0; i < 20; i++) begin
      trainOp(32'h100 + 32'(i * 4), i[0], 1'b1);
      if (i == 14) expectPerf("perf_at_15", 32'd15, 32'd15, 4'd15, 4'd15);
      if (i == 19) expectPerf("perf_saturated", 32'd20, 32'd20, 4'd15, 4'd15);
      if (perfQ.size() != 0) begin
        #1;
        pe = perfQ.pop_front();
        nChecks++;
        if ({perf_branch_o, perf_mispred_o, perf4Branch, perf4Mispred} !== {pe.branch, pe.mispred, pe.branch4, pe.mispred4}) begin
          nFails++;
          $display("[TB] FAIL %s: got br=%0d mp=%0d br4=%0d mp4=%0d expected br=%0d mp=%0d br4=%0d mp4=%0d",
                   pe.name, perf_branch_o, perf_mispred_o, perf4Branch, perf4Mispred,
                   pe.branch, pe.mispred, pe.branch4, pe.mispred4);
        end
      end
    end
  endtask

  initial begin
    rst_i                = 1'b0;
    F_PC_i               = 32'h0;
    F_instr_i            = 32'h0000_0013;
    E_train_vaild_i      = 1'b0;
    E_train_pc_i         = 32'h0;
    E_train_taken_i      = 1'b0;
    E_train_mispredict_i = 1'b0;
    test_reset();
    test_decode();
    test_train();
    test_alias();
    test_back_to_back();
    test_reset_priority();
    test_perf();
    test_perf_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fetch_bht_predictor.md
Name: fetch_bht_predictor

Overview:
- Fetch-stage next-PC predictor; successor to the static always-taken fetch predictor.
- Mini-decodes the fetched RV32I word (branch/jal), computes the target, and predicts conditional branches with a parametrised table of 2-bit saturating counters indexed by PC.
- The table is trained from execute.
- Keeps saturating performance counters for branches and mispredictions.

Parameters:
- PC_WIDTH, 32, fetch PC width.
- XLEN, 32, target/immediate width.
- BHT_DEPTH, 64, counter entries; power of two, 4..1024.
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).
- PERF_WIDTH, 32, perf counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- F_PC_i  in  PC_WIDTH  fetch PC
- F_instr_i  in  32  fetched instruction
- mini_jmp_sel_o  out  1  redirect fetch this cycle
- mini_jmp_o  out  XLEN  redirect target = F_PC_i + imm
- F_train_vaild_o  out  1  fetched instr is a conditional branch
- F_train_predict_o  out  1  predicted direction for the branch
- E_train_vaild_i  in  1  execute resolves a conditional branch
- E_train_pc_i  in  PC_WIDTH  PC of the resolved branch
- E_train_taken_i  in  1  actual direction
- E_train_mispredict_i  in  1  predicted direction was wrong
- perf_branch_o  out  PERF_WIDTH  resolved branches
- perf_mispred_o  out  PERF_WIDTH  mispredicted branches

Behaviour:
- Decode is combinational from F_instr_i.
  - op_branch: opcode[6:0] == 7'b1100011.
  - op_jal: opcode[6:0] == 7'b1101111.
  - B-imm and J-imm are sign-extended to XLEN.
  - Any other opcode gives imm = 0.
- Index = F_PC_i[IDX+1:2], where IDX = log2(BHT_DEPTH). PC bits [1:0] are ignored.
- F_train_predict_o = op_branch & bht[index][1]. It is 0 for non-branches.
- mini_jmp_sel_o = op_jal | F_train_predict_o.
- mini_jmp_o = F_PC_i + imm. The add is modulo 2^XLEN and always driven.
- F_train_vaild_o = op_branch.
- Prediction outputs have zero latency (same cycle as F_PC_i/F_instr_i) and depend only on inputs plus table state.
- Training: on a clk_i edge with E_train_vaild_i = 1, the entry at E_train_pc_i's index is updated.
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
  - The new value is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: the lookup sees the old value (no bypass).
- Perf counters, on a clk_i edge:
  - perf_branch_o increments on E_train_vaild_i.
  - perf_mispred_o increments on E_train_vaild_i & E_train_mispredict_i.
  - Both saturate at all-ones; they do not wrap.
  - E_train_mispredict_i is ignored when E_train_vaild_i = 0.
- Reset: on a clk_i edge with rst_i = 1:
  - All BHT entries are set to CNT_INIT in that single cycle.
  - Both perf counters are set to 0.
  - Training in the same cycle is discarded; reset has priority.
  - Combinational outputs during reset reflect the pre-reset table. From the cycle after reset, predictions are not-taken for every branch when CNT_INIT = 01.
- Aliasing: PCs that differ only above bit IDX+1 share an entry. This is by design.

Optional Feature:
- Macro: PRED_GSHARE_EN.
- Defined:
  - Adds an IDX-bit global history register ghr, reset to 0.
  - Lookup index = F_PC_i[IDX+1:2] ^ ghr.
  - Each valid training shifts ghr left and inserts E_train_taken_i at bit 0.
  - The training index uses a registered ghr_fetch snapshot: ghr captured whenever F_train_vaild_o = 1.
  - There is one snapshot, so only one branch is in flight.
  - On reset, ghr and the snapshot clear with the table.
- Undefined: no history logic; pure PC indexing as above.

Decomposition:
- Shared package/define file holds:
  - opcode constants OPC_BRANCH and OPC_JAL.
  - 2-bit counter encodings SNT, WNT, WT, ST.
  - The counter update function sat2_next(cnt, taken).
- One sub-module, bht_table: the counter array with async read port, sync write port, and sync reset. It is parametrised by BHT_DEPTH and CNT_INIT.
- Decode, target add and perf counters stay in the top module.

Test Plan:
- Reset, then F_PC_i = 0x100 with beq imm = +16 → F_train_vaild_o = 1, F_train_predict_o = 0, mini_jmp_sel_o = 0, mini_jmp_o = 0x110.
- jal imm = -8 at PC 0x200 → mini_jmp_sel_o = 1, mini_jmp_o = 0x1F8, F_train_vaild_o = 0.
- Train PC 0x100 taken once → the next cycle's lookup at 0x100 predicts 1. Train not-taken twice → predicts 0. Four takens followed by one not-taken → still predicts 1 (saturation at 11, then 10).
- Aliasing with BHT_DEPTH = 64: train PC 0x100 taken twice; lookup 0x200 (same index) → predict 1. Lookup 0x104 → predict 0.
- Same-cycle train and lookup of the same index from WNT with taken → the lookup that cycle gives 0, the next cycle gives 1. rst_i asserted together with a training update → entry stays CNT_INIT and perf counters read 0.
- 5 trainings, 2 with mispredict → perf_branch_o = 5, perf_mispred_o = 2. With PERF_WIDTH = 4, 20 trainings → perf_branch_o = 15 (saturated).
